mmio_io_responder: RTL
======================

// Module: mmio_io_responder
// PURPOSE
//  Device-side responder for the processor's memory-mapped I/O window. Sits between the
//  processor data-memory port and RAM: decodes button-status reads/clears at BTN_ADDR and
//  output writes at OUT_ADDR. Synchronises and debounces raw buttons, latches press events,
//  holds the output register, and passes all other accesses through to RAM unchanged.
// PARAMETERS
//  BTN_ADDR        1000  word address of the button status/clear register (full 32-bit compare)
//  OUT_ADDR        2000  word address of the output register (full 32-bit compare)
//  NUM_BTN         4     number of button inputs, 1..16
//  DEBOUNCE_CYCLES 16    consecutive stable cycles before a debounced level changes, >=1
// PORTS
//  clock         in   1        system clock, all state updates on posedge
//  reset         in   1        synchronous, active-high; clears all state
//  address_dmem  in   32       processor data address
//  wren          in   1        processor data write enable
//  data          in   32       processor write data
//  q_dmem        out  32       read data returned to processor (status or RAM)
//  ram_q         in   32       RAM read data (RAM has 1-cycle read latency)
//  ram_wren      out  1        RAM write enable, wren gated off for MMIO addresses
//  button_raw    in   NUM_BTN  asynchronous raw button levels
//  out_reg       out  32       output register contents
//  out_strobe    out  1        1-cycle pulse following every accepted OUT_ADDR write
// BEHAVIOUR
//  Reset: out_reg=0, out_strobe=0, sync/debounced levels=0, counters=0, press latches=0,
//   read-select flag=0 (q_dmem = ram_q). Reset mid-debounce discards the partial count.
//  Input path: 2-flop synchroniser per button. Debounce counter increments while the synced
//   level != debounced level, clears when equal; on the edge where the count reaches
//   DEBOUNCE_CYCLES-1 the debounced level toggles and the count clears. Raw change to
//   debounced change = 2+DEBOUNCE_CYCLES edges. A glitch shorter than DEBOUNCE_CYCLES is ignored.
//  Press latch[i]: set on the edge where debounced[i] goes 0->1; sticky until cleared.
//  Status word: [NUM_BTN-1:0]=debounced levels, [16+NUM_BTN-1:16]=press latches, other bits 0.
//  Read: on each edge, sel_btn <= (address_dmem==BTN_ADDR)&&!wren, status_q <= status word.
//   q_dmem = sel_btn ? status_q : ram_q (1-cycle latency, matching RAM). Reads have no side effects.
//  Clear: write to BTN_ADDR clears press latch[i] where data[i]=1 (write-1-to-clear).
//   Same-edge new press and clear on bit i: set wins (latch stays 1).
//  Output: write to OUT_ADDR loads out_reg<=data on that edge; out_strobe=1 for the following
//   cycle only. Back-to-back writes: out_reg tracks each, out_strobe stays high each cycle.
//  ram_wren = wren && address_dmem!=BTN_ADDR && address_dmem!=OUT_ADDR (combinational).
//   Reads at OUT_ADDR return ram_q (output register is write-only).
//  Arithmetic: counter width $clog2(DEBOUNCE_CYCLES)+1, saturates never exceeds DEBOUNCE_CYCLES-1.
// STRUCTURE
//  Package io_map_pkg: BTN_ADDR/OUT_ADDR constants, STATUS_LEVEL_LSB=0, STATUS_PRESS_LSB=16.
//  Sub-module button_debouncer (sync + counter + debounced level, one per button via
//   generate); top holds latches, address decode, read mux, output register.
// TESTING
//  Reset: assert reset 2 cycles -> out_reg=0, out_strobe=0, read of 1000 returns 0x0.
//  Debounce, DEBOUNCE_CYCLES=4: button_raw[0] high 3 cycles then low -> status stays 0x0;
//   high held -> status 0x0001_0001 exactly 6 edges after raw rise.
//  Output: sw 0x0000DEAD to 2000 -> out_reg=0xDEAD next edge, out_strobe high 1 cycle, ram_wren=0.
//  Clear: with latch[0]=1, write 0x1 to 1000 -> status 0x0000_0001; clear on same edge as
//   a button[1] press edge with data=0x2 -> latch[1] remains set.
//  Passthrough: write 0x55 to addr 5 -> ram_wren=1; read addr 5 -> q_dmem = ram_q (0x55).
//  Reset mid-debounce: raw high, reset at cycle 3 of 4 -> count lost, level 0; needs full 2+4 again.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared address map and status-word layout for the MMIO I/O responder.
package io_map_pkg;

    // Word addresses decoded by the responder; every other address goes to RAM.
    localparam logic [31:0] BTN_ADDR = 32'd1000;
    localparam logic [31:0] OUT_ADDR = 32'd2000;

    // Bit positions of the two fields packed into the button status word.
    localparam int STATUS_LEVEL_LSB = 0;
    localparam int STATUS_PRESS_LSB = 16;

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser plus debounce filter for a single raw button input.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw_i,
    output logic level_o,
    output logic rise_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Count consecutive disagreeing samples; toggle the level once the run is long enough.
    always_comb begin
        level_d = level_q;
        count_d = '0;
        if (sync2_q != level_q) begin
            if (count_q == LAST_COUNT) begin
                level_d = ~level_q;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Two-flop synchroniser followed by the debounce state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            count_q <= '0;
        end else begin
            sync1_q <= button_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            count_q <= count_d;
        end
    end

    assign level_o = level_q;
    // Rise is visible on the same edge the level flips, so the press latch sets in step.
    assign rise_o  = level_d & ~level_q;

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder: button status/clear, output register, RAM passthrough.
module mmio_io_responder
    import io_map_pkg::*;
#(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        address_dmem,
    input  logic               wren,
    input  logic [31:0]        data,
    output logic [31:0]        q_dmem,
    input  logic [31:0]        ram_q,
    output logic               ram_wren,
    input  logic [NUM_BTN-1:0] button_raw,
    output logic [31:0]        out_reg,
    output logic               out_strobe
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] latch_q;
    logic [NUM_BTN-1:0] latch_d;
    logic [NUM_BTN-1:0] clrMask;
    logic [31:0]        statusWord;
    logic [31:0]        status_q;
    logic               selBtn_q;
    logic [31:0]        outReg_q;
    logic               outStrobe_q;
    logic               isBtn;
    logic               isOut;

    for (genvar g = 0; g < NUM_BTN; g++) begin : gen_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clock       (clock),
            .reset       (reset),
            .button_raw_i(button_raw[g]),
            .level_o     (level[g]),
            .rise_o      (rise[g])
        );
    end

    assign isBtn = (address_dmem == BTN_ADDR);
    assign isOut = (address_dmem == OUT_ADDR);

    // Write-1-to-clear mask; a new press on the same edge overrides its clear bit.
    always_comb begin
        clrMask = '0;
        if (isBtn && wren) begin
            clrMask = data[NUM_BTN-1:0];
        end
        latch_d = (latch_q & ~clrMask) | rise;
    end

    // Pack debounced levels and press latches into the readable status word.
    always_comb begin
        statusWord = '0;
        statusWord[STATUS_LEVEL_LSB +: NUM_BTN] = level;
        statusWord[STATUS_PRESS_LSB +: NUM_BTN] = latch_q;
    end

    // Press latches, read-select pipeline stage and the output register.
    always_ff @(posedge clock) begin
        if (reset) begin
            latch_q     <= '0;
            selBtn_q    <= 1'b0;
            status_q    <= '0;
            outReg_q    <= '0;
            outStrobe_q <= 1'b0;
        end else begin
            latch_q     <= latch_d;
            selBtn_q    <= isBtn && !wren;
            status_q    <= statusWord;
            outStrobe_q <= isOut && wren;
            if (isOut && wren) begin
                outReg_q <= data;
            end
        end
    end

    assign q_dmem     = selBtn_q ? status_q : ram_q;
    assign ram_wren   = wren && !isBtn && !isOut;
    assign out_reg    = outReg_q;
    assign out_strobe = outStrobe_q;

endmodule
